apb_master_bridge: RTL and testbench

//  APB requester (initiator) that drives the completer side of the UART and GPIO peripherals.

---
 rtl/apb_master_bridge_pkg.sv | 16 +
 rtl/apb_master_bridge_addr_decoder.sv | 22 ++
 rtl/apb_master_bridge.sv | 167 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_bridge_pkg.sv
// Shared definitions for the APB requester bridge.
//   apb_state_e : bridge FSM state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
//   UartIdx/GpioIdx : slave-index values decoded from the address select field
package apb_master_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StResp   = 2'd3
    } apb_state_e;

    localparam int unsigned UartIdx = 0;
    localparam int unsigned GpioIdx = 1;

endpackage

// File: rtl/apb_master_bridge_addr_decoder.sv
// Combinational slave decoder for the APB bridge.
//   sel_field_i  : slave-index field taken from the command address
//   sel_o        : one-hot PSEL pattern for the addressed slave (0 if unmapped)
//   unmapped_o   : index does not name an existing slave
module apb_master_bridge_addr_decoder #(
    parameter int unsigned NUM_SLAVES = 2,
    parameter int unsigned SEL_BITS   = 4
) (
    input  logic [SEL_BITS-1:0]   sel_field_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  unmapped_o
);

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_o[i] = (sel_field_i == SEL_BITS'(i));
        end
        unmapped_o = ~|sel_o;
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready commands into APB SETUP/ACCESS transfers
// and returns read data plus an error flag on a valid/ready response port.
//   PCLK/PRESET          : clock, synchronous active-high reset
//   cmd_*                : command port (write, addr, wdata)
//   rsp_*                : response port (rdata, error)
//   PSELx..PWDATA        : APB requester outputs
//   PRDATA/PREADY/PSLVERR: per-slave APB completer inputs
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned SEL_LSB        = 12,
    parameter int unsigned SEL_BITS       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic                             cmd_write,
    input  logic [ADDR_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH-1:0]            cmd_wdata,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_error,
    output logic [NUM_SLAVES-1:0]            PSELx,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    apb_state_e              state_q, state_d;
    logic                    write_q, write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    error_q, error_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_unmapped;
    logic [DATA_WIDTH-1:0]   prdata_sel;
    logic                    pready_sel;
    logic                    pslverr_sel;

    apb_master_bridge_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SEL_BITS   (SEL_BITS)
    ) u_addr_decoder (
        .sel_field_i (cmd_addr[SEL_LSB +: SEL_BITS]),
        .sel_o       (dec_sel),
        .unmapped_o  (dec_unmapped)
    );

    // Only the selected slave's completer signals are looked at.
    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                prdata_sel = prdata_sel | PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        pready_sel  = |(PREADY & sel_q);
        pslverr_sel = |(PSLVERR & sel_q);
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    cnt_d = '0;
                    if (dec_unmapped) begin
                        // No bus cycle: respond with an error straight away.
                        sel_d   = '0;
                        rdata_d = '0;
                        error_d = 1'b1;
                        state_d = StResp;
                    end else begin
                        write_d = cmd_write;
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                        sel_d   = dec_sel;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                cnt_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                // PREADY takes priority over a simultaneous timeout.
                if (pready_sel) begin
                    rdata_d = (write_q || pslverr_sel) ? '0 : prdata_sel;
                    error_d = pslverr_sel;
                    state_d = StResp;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        cmd_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_error = rsp_valid & error_q;
        PSELx     = (state_q == StSetup || state_q == StAccess) ? sel_q : '0;
        PENABLE   = (state_q == StAccess);
        PWRITE    = write_q;
        PADDR     = addr_q;
        PWDATA    = wdata_q;
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge with a two-slave APB completer model.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic [1:0]  PSELx;
    logic        PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [63:0] PRDATA;
    logic [1:0]  PREADY, PSLVERR;

    // Completer model: slave i raises PREADY after ws[i] wait states when rdy_en[i].
    logic [1:0]  rdy_en;
    logic [1:0]  slverr;
    int          ws [2];
    logic [31:0] uart_rdata, gpio_rdata;
    int          acc_cnt = 0;

    assign PRDATA  = {gpio_rdata, uart_rdata};
    assign PSLVERR = slverr;
    assign PREADY  = {rdy_en[GpioIdx] && (acc_cnt >= ws[GpioIdx]),
                      rdy_en[UartIdx] && (acc_cnt >= ws[UartIdx])};

    always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

    always #5 PCLK = ~PCLK;

    apb_master_bridge dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .PSELx     (PSELx),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Observations of the last transfer.
    int          lat, en_cycles;
    logic [1:0]  sel_seen;
    logic [31:0] paddr_setup, pwdata_setup;
    logic        pwrite_setup;

    // Issue one command from IDLE and run until rsp_valid (bounded).
    task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step();
        cmd_valid = 1'b0;
        lat = 1;
        en_cycles = 0;
        sel_seen = '0;
        paddr_setup = PADDR;
        pwdata_setup = PWDATA;
        pwrite_setup = PWRITE;
        while (!rsp_valid && lat < 40) begin
            sel_seen = sel_seen | PSELx;
            if (PENABLE) en_cycles++;
            step();
            lat++;
        end
    endtask

    initial begin
        PRESET = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1;
        rdy_en = 2'b00; slverr = 2'b00; ws[0] = 0; ws[1] = 0;
        uart_rdata = '0; gpio_rdata = '0;
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_psel", PSELx, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        PRESET = 1'b0;
        step();

        // 1: UART write, PREADY tied high.
        rdy_en = 2'b01; uart_rdata = 32'h1111_2222;
        do_cmd(1'b1, 32'h0000_0000, 32'h0000_00AA);
        check("t1_paddr", paddr_setup, 32'h0);
        check("t1_pwdata", pwdata_setup, 32'hAA);
        check("t1_pwrite", pwrite_setup, 1);
        check("t1_sel", sel_seen, 2'b01);
        check("t1_en_cycles", en_cycles, 1);
        check("t1_latency", lat, 3);
        check("t1_error", rsp_error, 0);
        check("t1_rdata", rsp_rdata, 0);
        check("t1_psel_resp", PSELx, 0);
        check("t1_cmd_ready_resp", cmd_ready, 0);
        step();
        check("t1_back_idle", cmd_ready, 1);

        // 2: GPIO read with 3 wait states.
        rdy_en = 2'b10; ws[1] = 3; gpio_rdata = 32'h0000_00F0;
        do_cmd(1'b0, 32'h0000_1000, 32'h0);
        check("t2_sel", sel_seen, 2'b10);
        check("t2_en_cycles", en_cycles, 4);
        check("t2_latency", lat, 6);
        check("t2_rdata", rsp_rdata, 32'hF0);
        check("t2_error", rsp_error, 0);
        step();

        // 3: UART read completing with PSLVERR.
        rdy_en = 2'b01; ws[0] = 0; slverr = 2'b01; uart_rdata = 32'h0000_1234;
        do_cmd(1'b0, 32'h0000_0040, 32'h0);
        check("t3_error", rsp_error, 1);
        check("t3_rdata", rsp_rdata, 0);
        slverr = 2'b00;
        step();

        // 4: unmapped index 5 -> no bus activity.
        rdy_en = 2'b11;
        do_cmd(1'b0, 32'h0000_5000, 32'h0);
        check("t4_sel", sel_seen, 0);
        check("t4_en_cycles", en_cycles, 0);
        check("t4_latency", lat, 1);
        check("t4_error", rsp_error, 1);
        check("t4_rdata", rsp_rdata, 0);
        step();

        // 5: UART never ready; GPIO ready must be ignored.
        rdy_en = 2'b10; ws[1] = 0; gpio_rdata = 32'hDEAD_BEEF;
        do_cmd(1'b0, 32'h0000_0000, 32'h0);
        check("t5_en_cycles", en_cycles, 16);
        check("t5_latency", lat, 18);
        check("t5_error", rsp_error, 1);
        check("t5_rdata", rsp_rdata, 0);
        step();

        // 5b: PREADY on the final allowed ACCESS cycle wins over the timeout.
        rdy_en = 2'b10; ws[1] = 15; gpio_rdata = 32'h0BAD_F00D;
        do_cmd(1'b0, 32'h0000_1008, 32'h0);
        check("t5b_en_cycles", en_cycles, 16);
        check("t5b_error", rsp_error, 0);
        check("t5b_rdata", rsp_rdata, 32'h0BAD_F00D);
        step();

        // 6a: response back-pressure holds the response.
        rdy_en = 2'b10; ws[1] = 0; gpio_rdata = 32'h0000_CAFE;
        rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h0000_1004, 32'h0);
        gpio_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("t6_rsp_valid_hold", rsp_valid, 1);
            check("t6_rdata_hold", rsp_rdata, 32'h0000_CAFE);
            check("t6_cmd_ready_low", cmd_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("t6_idle_after_ready", cmd_ready, 1);
        check("t6_rsp_dropped", rsp_valid, 0);

        // 6b: reset during ACCESS aborts without a response.
        rdy_en = 2'b00;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = '0;
        step();
        cmd_valid = 1'b0;
        step();
        check("t6b_in_access", PENABLE, 1);
        PRESET = 1'b1;
        step();
        PRESET = 1'b0;
        check("t6b_psel_drop", PSELx, 0);
        check("t6b_penable_drop", PENABLE, 0);
        check("t6b_cmd_ready", cmd_ready, 1);
        check("t6b_no_rsp", rsp_valid, 0);
        step();
        step();
        check("t6b_still_no_rsp", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
